// File: rtl/di_enc_pkg.sv
// Shared quadrature definitions for the encoder input decoder and the output generator.
// Holds the EDGE state constants, the per-cycle step encoding and the default counter width.
package di_enc_pkg;

    localparam int DEFAULT_CNT_W = 32;

    // Forward sequence EDGE_1 -> EDGE_2 -> EDGE_3 -> EDGE_4 -> EDGE_1, encoded as {A,B}
    localparam logic [1:0] ENC_EDGE_1 = 2'b00;
    localparam logic [1:0] ENC_EDGE_2 = 2'b10;
    localparam logic [1:0] ENC_EDGE_3 = 2'b11;
    localparam logic [1:0] ENC_EDGE_4 = 2'b01;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    function automatic logic [1:0] enc_next(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            ENC_EDGE_1: nxt = ENC_EDGE_2;
            ENC_EDGE_2: nxt = ENC_EDGE_3;
            ENC_EDGE_3: nxt = ENC_EDGE_4;
            default:    nxt = ENC_EDGE_1;
        endcase
        return nxt;
    endfunction

    function automatic step_e enc_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        step_e s;
        if (cur_ab == prev_ab) begin
            s = STEP_NONE;
        end else if (cur_ab == enc_next(prev_ab)) begin
            s = STEP_UP;
        end else if (prev_ab == enc_next(cur_ab)) begin
            s = STEP_DN;
        end else begin
            s = STEP_ERR;
        end
        return s;
    endfunction

endpackage

// File: rtl/di_enc_filter.sv
// Single-bit stability filter: the output follows the input only after FILT_LEN
// consecutive identical samples, so shorter pulses are rejected.
module di_enc_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic xclk,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    // The counter holds the run length of samples that disagree with the output
    always_comb begin
        cnt_d = '0;
        out_d = out_q;
        if (din != out_q) begin
            if (cnt_q >= CNT_LAST) begin
                out_d = din;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Data-path flops: left unreset so the filter keeps tracking the lines during reset
    always_ff @(posedge xclk) begin
        cnt_q <= cnt_d;
        out_q <= out_d;
    end

    assign dout = out_q;

endmodule

// File: rtl/di_enc.sv
// di_enc: quadrature encoder input decoder (x4 position, direction, index latch, edge period).
// Define DI_ENC_GLITCH_FILTER_EN to insert a FILT_LEN stability filter on A, B and I.
module di_enc
    import di_enc_pkg::*;
#(
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int FILT_LEN = 4
) (
    input  logic             xclk,
    input  logic             reset,
    input  logic             enca_input,
    input  logic             encb_input,
    input  logic             enci_input,
    input  logic             clear_count,
    output logic [CNT_W-1:0] position_count,
    output logic             direction,
    output logic [CNT_W-1:0] index_position,
    output logic             index_seen,
    output logic             quad_error,
    output logic [CNT_W-1:0] edge_period,
    output logic             period_sat
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    if (FILT_LEN < 2 || FILT_LEN > 16) begin : g_filt_len_chk
        $error("di_enc: FILT_LEN must be in 2..16");
    end

    logic [2:0] sync1_q, sync2_q, dec_abi;

    // Synchronisers are unreset so the priming sample at reset release is the live line state
    always_ff @(posedge xclk) begin
        sync1_q <= {enca_input, encb_input, enci_input};
        sync2_q <= sync1_q;
    end

`ifdef DI_ENC_GLITCH_FILTER_EN
    for (genvar g = 0; g < 3; g++) begin : g_filt
        di_enc_filter #(.FILT_LEN(FILT_LEN)) u_filt (
            .xclk (xclk),
            .din  (sync2_q[g]),
            .dout (dec_abi[g])
        );
    end
`else
    assign dec_abi = sync2_q;
`endif

    logic [1:0]       dec_ab;
    logic             dec_i;
    logic             primed_q, primed_d;
    logic [1:0]       prev_ab_q, prev_ab_d;
    logic             prev_i_q, prev_i_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] idx_pos_q, idx_pos_d;
    logic             idx_seen_q, idx_seen_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] interval_inc;
    step_e            step;
    logic             idx_rise;

    assign dec_ab       = dec_abi[2:1];
    assign dec_i        = dec_abi[0];
    assign interval_inc = (interval_q == CNT_MAX) ? CNT_MAX : interval_q + CNT_ONE;

    always_comb begin
        primed_d   = 1'b1;
        prev_ab_d  = dec_ab;
        prev_i_d   = dec_i;
        pos_d      = pos_q;
        dir_d      = dir_q;
        idx_pos_d  = idx_pos_q;
        idx_seen_d = idx_seen_q;
        err_d      = err_q;
        period_d   = period_q;
        interval_d = interval_inc;
        // Until primed, the previous-state register is just loaded: no step, no index edge
        step       = primed_q ? enc_step(prev_ab_q, dec_ab) : STEP_NONE;
        idx_rise   = primed_q & dec_i & ~prev_i_q;

        if (clear_count) begin
            pos_d      = '0;
            idx_pos_d  = '0;
            idx_seen_d = 1'b0;
            err_d      = 1'b0;
            period_d   = '0;
            interval_d = '0;
        end else begin
            case (step)
                STEP_UP: begin
                    pos_d = pos_q + CNT_ONE;
                    dir_d = 1'b1;
                end
                STEP_DN: begin
                    pos_d = pos_q - CNT_ONE;
                    dir_d = 1'b0;
                end
                STEP_ERR: err_d = 1'b1;
                default: ;
            endcase
            if (step == STEP_UP || step == STEP_DN) begin
                period_d   = interval_inc;
                interval_d = '0;
            end
            // Latch the post-step position so a coincident step is included
            if (idx_rise) begin
                idx_pos_d  = pos_d;
                idx_seen_d = 1'b1;
            end
        end
        sat_d = (interval_d == CNT_MAX);
    end

    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            primed_q   <= 1'b0;
            prev_ab_q  <= '0;
            prev_i_q   <= 1'b0;
            pos_q      <= '0;
            dir_q      <= 1'b0;
            idx_pos_q  <= '0;
            idx_seen_q <= 1'b0;
            err_q      <= 1'b0;
            interval_q <= '0;
            period_q   <= '0;
            sat_q      <= 1'b0;
        end else begin
            primed_q   <= primed_d;
            prev_ab_q  <= prev_ab_d;
            prev_i_q   <= prev_i_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            idx_pos_q  <= idx_pos_d;
            idx_seen_q <= idx_seen_d;
            err_q      <= err_d;
            interval_q <= interval_d;
            period_q   <= period_d;
            sat_q      <= sat_d;
        end
    end

    assign position_count = pos_q;
    assign direction      = dir_q;
    assign index_position = idx_pos_q;
    assign index_seen     = idx_seen_q;
    assign quad_error     = err_q;
    assign edge_period    = period_q;
    assign period_sat     = sat_q;

endmodule

// File: tb/tb_di_enc.sv
// Scoreboard bench for di_enc: a phase-arithmetic reference model predicts every cycle,
// a negedge monitor compares; a second 8-bit instance exercises period saturation.
module tb_di_enc;

    localparam int FILT_LEN = 4;

    logic        xclk = 1'b0;
    logic        reset = 1'b0;
    logic        enc_a = 1'b1, enc_b = 1'b1, enc_i = 1'b0;
    logic        clr = 1'b0;

    logic [31:0] pos, ipos, per;
    logic        dir, seen, err, sat;
    logic [7:0]  s_pos, s_ipos, s_per;
    logic        s_dir, s_seen, s_err, s_sat;

    always #5 xclk = ~xclk;

    di_enc #(.CNT_W(32), .FILT_LEN(FILT_LEN)) u_dut (
        .xclk(xclk), .reset(reset), .enca_input(enc_a), .encb_input(enc_b),
        .enci_input(enc_i), .clear_count(clr), .position_count(pos), .direction(dir),
        .index_position(ipos), .index_seen(seen), .quad_error(err),
        .edge_period(per), .period_sat(sat)
    );

    di_enc #(.CNT_W(8), .FILT_LEN(FILT_LEN)) u_dut_small (
        .xclk(xclk), .reset(reset), .enca_input(enc_a), .encb_input(enc_b),
        .enci_input(enc_i), .clear_count(clr), .position_count(s_pos), .direction(s_dir),
        .index_position(s_ipos), .index_seen(s_seen), .quad_error(s_err),
        .edge_period(s_per), .period_sat(s_sat)
    );

    typedef struct packed {
        logic [31:0] pos;
        logic        dir;
        logic [31:0] ipos;
        logic        seen;
        logic        err;
        logic [31:0] per;
        logic        sat;
        logic [7:0]  spos;
        logic [7:0]  sper;
        logic        ssat;
    } snap_t;

    typedef struct {
        string       name;
        int          fld;
        logic [31:0] val;
    } anchor_t;

    snap_t   exp_q[$];
    anchor_t anc_q[$];
    int      total = 0;
    int      bad = 0;

    // ---------------- reference model ----------------
    logic [2:0]  hist[$];
    longint      edge_no = 0;
    longint      mark = 0;
    bit          m_primed = 0;
    int          m_prev_ph = 0;
    logic        m_prev_i = 1'b0;
    logic [31:0] m_pos = 0, m_ipos = 0, m_per = 0;
    logic        m_dir = 0, m_seen = 0, m_err = 0;
    logic [7:0]  m_sper = 0;
    logic [2:0]  f_val = 3'b000, f_last = 3'b000;
    int          f_run[3] = '{0, 0, 0};

    function automatic int phase_of(input logic [1:0] ab);
        int p;
        case (ab)
            2'b00: p = 0;
            2'b10: p = 1;
            2'b11: p = 2;
            default: p = 3;
        endcase
        return p;
    endfunction

    always @(posedge xclk) begin
        logic [2:0] s, d;
        int         ph, dlt;
        longint     gap;
        snap_t      e;
        edge_no++;
        hist.push_back({enc_a, enc_b, enc_i});
        s = 3'b000;
        if (hist.size() > 2) s = hist.pop_front();
`ifdef DI_ENC_GLITCH_FILTER_EN
        d = f_val;
        for (int k = 0; k < 3; k++) begin
            if (s[k] == f_last[k]) f_run[k]++;
            else f_run[k] = 1;
            f_last[k] = s[k];
            if (f_run[k] >= FILT_LEN) f_val[k] = s[k];
        end
`else
        d = s;
`endif
        ph = phase_of(d[2:1]);
        if (!reset) begin
            m_pos = 0; m_ipos = 0; m_per = 0; m_sper = 0;
            m_dir = 0; m_seen = 0; m_err = 0;
            m_primed = 0; m_prev_ph = 0; m_prev_i = 0;
            mark = edge_no;
        end else begin
            if (clr) begin
                m_pos = 0; m_ipos = 0; m_per = 0; m_sper = 0;
                m_seen = 0; m_err = 0;
                mark = edge_no;
            end else if (m_primed) begin
                dlt = (ph - m_prev_ph + 4) % 4;
                if (dlt == 1) begin m_pos = m_pos + 1; m_dir = 1; end
                if (dlt == 3) begin m_pos = m_pos - 1; m_dir = 0; end
                if (dlt == 2) m_err = 1;
                if (dlt == 1 || dlt == 3) begin
                    gap    = edge_no - mark;
                    m_per  = (gap > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : gap[31:0];
                    m_sper = (gap > 255) ? 8'hFF : gap[7:0];
                    mark   = edge_no;
                end
                if (d[0] && !m_prev_i) begin m_ipos = m_pos; m_seen = 1; end
            end
            m_primed  = 1;
            m_prev_ph = ph;
            m_prev_i  = d[0];
        end
        e.pos  = m_pos;   e.dir  = m_dir;  e.ipos = m_ipos; e.seen = m_seen;
        e.err  = m_err;   e.per  = m_per;  e.spos = m_pos[7:0]; e.sper = m_sper;
        e.sat  = (edge_no - mark) >= 64'hFFFF_FFFF;
        e.ssat = (edge_no - mark) >= 255;
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    function automatic logic [31:0] fld_val(input int f);
        logic [31:0] v;
        case (f)
            0: v = pos;
            1: v = {31'd0, dir};
            2: v = ipos;
            3: v = {31'd0, seen};
            4: v = {31'd0, err};
            5: v = per;
            6: v = {31'd0, sat};
            7: v = {24'd0, s_per};
            default: v = {31'd0, s_sat};
        endcase
        return v;
    endfunction

    always @(negedge xclk) begin
        snap_t   e, a;
        anchor_t an;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (!reset) e = '0;
            a.pos  = pos;  a.dir  = dir;  a.ipos = ipos; a.seen = seen; a.err = err;
            a.per  = per;  a.sat  = sat;  a.spos = s_pos; a.sper = s_per; a.ssat = s_sat;
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL scoreboard t=%0t got pos=%h dir=%b ipos=%h seen=%b err=%b per=%h sat=%b spos=%h sper=%h ssat=%b | want pos=%h dir=%b ipos=%h seen=%b err=%b per=%h sat=%b spos=%h sper=%h ssat=%b",
                         $time, a.pos, a.dir, a.ipos, a.seen, a.err, a.per, a.sat, a.spos, a.sper, a.ssat,
                         e.pos, e.dir, e.ipos, e.seen, e.err, e.per, e.sat, e.spos, e.sper, e.ssat);
            end
        end
        while (anc_q.size() != 0) begin
            an = anc_q.pop_front();
            total++;
            if (fld_val(an.fld) !== an.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", an.name, fld_val(an.fld), an.val);
            end
        end
    end

    // ---------------- stimulus ----------------
    int   cur_ph = 2;
    logic cur_i = 1'b0;

    task automatic go(input int ph, input logic i, input int hold);
        cur_ph = ph;
        cur_i  = i;
        enc_a  = (ph == 1 || ph == 2);
        enc_b  = (ph == 2 || ph == 3);
        enc_i  = i;
        repeat (hold) begin @(posedge xclk); #1; end
    endtask

    task automatic fwd(input int n, input int hold);
        for (int k = 0; k < n; k++) go((cur_ph + 1) % 4, cur_i, hold);
    endtask

    task automatic rev(input int n, input int hold);
        for (int k = 0; k < n; k++) go((cur_ph + 3) % 4, cur_i, hold);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge xclk); #1;
        clr = 1'b0;
    endtask

    task automatic anchor(input string name, input int f, input logic [31:0] v);
        anchor_t an;
        an.name = name; an.fld = f; an.val = v;
        anc_q.push_back(an);
    endtask

    initial begin
        int r;
        go(2, 1'b0, 8);
        reset = 1'b1;
        go(2, 1'b0, 12);
        anchor("prime_11_no_err", 4, 32'd0);
        anchor("prime_pos", 0, 32'd0);

        fwd(4, 10);
        anchor("fwd4_pos", 0, 32'd4);
        anchor("fwd4_dir", 1, 32'd1);
        anchor("fwd4_err", 4, 32'd0);

        pulse_clr();
        go(cur_ph, 1'b0, 6);
        rev(3, 10);
        anchor("rev3_wrap", 0, 32'hFFFF_FFFD);
        anchor("rev3_dir", 1, 32'd0);
        fwd(3, 10);
        anchor("fwd3_back_zero", 0, 32'd0);

        fwd(2, 10);
        go((cur_ph + 2) % 4, 1'b0, 10);
        anchor("illegal_hold_pos", 0, 32'd2);
        anchor("illegal_err", 4, 32'd1);
        go(cur_ph, 1'b0, 20);
        anchor("err_sticky", 4, 32'd1);
        pulse_clr();
        go(cur_ph, 1'b0, 8);
        anchor("clr_err", 4, 32'd0);
        anchor("clr_pos", 0, 32'd0);

        fwd(41, 3);
        go((cur_ph + 1) % 4, 1'b1, 10);
        anchor("index_pos_42", 2, 32'd42);
        anchor("index_seen", 3, 32'd1);
        go(cur_ph, 1'b0, 5);

        fwd(3, 100);
        anchor("period_100", 5, 32'd100);
        go(cur_ph, 1'b0, 300);
        anchor("small_sat", 8, 32'd1);
        anchor("main_not_sat", 6, 32'd0);
        fwd(1, 10);
        anchor("small_period_sat", 7, 32'hFF);
        anchor("small_sat_clear", 8, 32'd0);

        fwd(2, 6);
        reset = 1'b0;
        go(cur_ph, 1'b0, 4);
        anchor("reset_pos", 0, 32'd0);
        anchor("reset_seen", 3, 32'd0);
        reset = 1'b1;
        go(cur_ph, 1'b0, 12);
        anchor("rerelease_err", 4, 32'd0);

`ifdef DI_ENC_GLITCH_FILTER_EN
        go((cur_ph + 1) % 4, 1'b0, 3);
        go((cur_ph + 3) % 4, 1'b0, 12);
        anchor("glitch_rejected", 0, 32'd0);
        go((cur_ph + 1) % 4, 1'b0, 6);
        anchor("filt_before_7", 0, 32'd0);
        go(cur_ph, 1'b0, 1);
        anchor("filt_at_7", 0, 32'd1);
        go(cur_ph, 1'b0, 10);
`endif

        for (int n = 0; n < 1200; n++) begin
            logic ni;
            int   hold;
            r    = $urandom_range(0, 99);
            ni   = ($urandom_range(0, 4) == 0) ? ~cur_i : cur_i;
            hold = $urandom_range(2, 8);
            if (r < 45)      go((cur_ph + 1) % 4, ni, hold);
            else if (r < 80) go((cur_ph + 3) % 4, ni, hold);
            else if (r < 95) go(cur_ph, ni, hold);
            else             go((cur_ph + 2) % 4, ni, hold);
            if ($urandom_range(0, 39) == 0) pulse_clr();
        end

        go(cur_ph, cur_i, 20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/di_enc.md
# di_enc

Quadrature encoder input decoder: the receive-side counterpart to the encoder output generator in the digital-output path. It synchronises externally driven A/B/Index lines to `xclk`, decodes x4 quadrature transitions into a signed 32-bit position, and reports direction, index-latched position, edge period and illegal-transition errors. It sits in the digital-input path and is read and cleared by the DSP bus logic.

## Interface
Parameters:
- `CNT_W`, 32: width of the position, index-latch and period counters.
- `FILT_LEN`, 4: number of consecutive equal samples required by the glitch filter. Only used when the filter is compiled in. Legal range 2..16.

Ports:
- `xclk` in 1: 75 MHz system clock. Single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `enca_input` in 1: encoder A. Asynchronous.
- `encb_input` in 1: encoder B. Asynchronous.
- `enci_input` in 1: encoder Index. Asynchronous.
- `clear_count` in 1: synchronous, active-high, one or more cycles. Issued by the DSP.
- `position_count` out CNT_W: two's-complement position.
- `direction` out 1: 1 = A leads B (count up), 0 = B leads A. Reflects the last valid edge.
- `index_position` out CNT_W: `position_count` captured at the most recent Index rising edge.
- `index_seen` out 1: sticky. Set on an Index rising edge.
- `quad_error` out 1: sticky. Set on an illegal transition.
- `edge_period` out CNT_W: number of `xclk` cycles between the last two valid edges.
- `period_sat` out 1: the running interval counter has saturated (encoder stopped).

## Operation
Input path:
- Each input passes through a 2-flop synchronizer.
- If the filter is compiled in, the filter follows the synchronizer.
- The result is the decoded A, B and I.

Quadrature states (A,B):
- The forward sequence is 00→10→11→01→00. These are EDGE_1..EDGE_4, matching the output generator.
- A forward step does +1 and sets `direction`=1.
- A reverse step does −1 and sets `direction`=0.
- No change: hold.
- Both A and B change in one cycle: illegal. Count and direction hold, and `quad_error` is set.

Priming:
- In the first cycle after `reset` deasserts, the previous-state register loads the current decoded A,B without decoding.
- An input of 11 at reset release must therefore not flag an error.

Arithmetic:
- `position_count` wraps modulo 2^CNT_W: 0xFFFFFFFF +1 → 0, and 0 −1 → 0xFFFFFFFF.

Index handling, on a decoded I rising edge (0→1):
- `index_position` is loaded with the post-update `position_count` of that same cycle, including any coincident count step.
- `index_seen` is set to 1.
- Index is direction-agnostic.

Period measurement:
- The interval counter increments every cycle and saturates at all-ones.
- While saturated, `period_sat`=1.
- On a valid edge: `edge_period` is loaded with interval+1 (saturating), the interval counter is cleared to 0, and `period_sat` is cleared.

`clear_count`:
- Clears `position_count`, `index_position`, `edge_period`, the interval counter, `index_seen`, `quad_error` and `period_sat`.
- It has priority over a coincident edge or index: the event is discarded, but the previous-state register still updates so that no spurious step occurs afterwards.

## Timing
- Reset values: every output is 0. The previous-state register and the primed flag are 0.
- Latency without the filter: an input edge is reflected in `position_count` 3 `xclk` rising edges later (2 synchronizer stages + 1 decode register).
- Latency with the filter: an additional FILT_LEN cycles.
- `index_position`, `index_seen`, `quad_error` and `edge_period` update in the same cycle as `position_count`.
- Maximum trackable rate is one state change per 2 cycles at the decoder input. Faster input is undefined; it typically produces `quad_error`.
- When `reset` asserts mid-operation, all state clears immediately (asynchronous). The priming rule applies again on release.

## Configuration
Macro: `DI_ENC_GLITCH_FILTER_EN`.
- Defined: each of A, B and I passes through a filter. The filtered output changes only after FILT_LEN consecutive identical synchronized samples. Pulses shorter than FILT_LEN cycles are rejected.
- Undefined: the filter is absent, synchronized samples feed the decoder directly, and FILT_LEN is ignored.

## Structure
- Package `di_enc_pkg` holds:
  - the ENC_EDGE_1..ENC_EDGE_4 state constants, shared with the output generator;
  - the step encoding constants STEP_NONE, STEP_UP, STEP_DN, STEP_ERR;
  - the default CNT_W.
- Sub-module `di_enc_filter`: a single-bit stability filter. It is instantiated 3 times, and only under the macro.

## Test plan
- Forward sequence 00→10→11→01→00, each state held 10 cycles → `position_count`=4, `direction`=1, no `quad_error`.
- From `position_count`=0, reverse 3 steps → 0xFFFFFFFD, `direction`=0. Then forward 3 steps → 0.
- 00→11 directly → count holds, `quad_error`=1 and stays 1. `clear_count` pulse → `quad_error`=0 and `position_count`=0.
- Index rising edge coincident with a forward step from 41 → `index_position`=42, `index_seen`=1.
- Edges spaced 100 cycles apart → `edge_period`=100. No edges for 2^32 cycles (or a forced counter) → `period_sat`=1.
- With `DI_ENC_GLITCH_FILTER_EN` and FILT_LEN=4: a 3-cycle A glitch → no count. A 4-cycle-stable change → count steps, 7 cycles after the input change.
